// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and helpers for the sequential radix-4 Booth multiplier
package booth_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef enum logic [2:0] {SEL_ZERO, SEL_P1, SEL_P2, SEL_N1, SEL_N2} sel_t;

    // One group per bit pair plus a top group that keeps unsigned operands exact.
    function automatic int ngrp_of(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_sel_gen.sv
// rtl/booth_sel_gen.sv - single-group radix-4 Booth selector (0, +X, +2X, -X, -2X)
module booth_sel_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] mcand,
    output logic [WIDTH+2:0] sel_val,
    output logic             neg
);

    sel_t             sel;
    logic [WIDTH+2:0] x1;
    logic [WIDTH+2:0] x2;

    assign x1 = {mcand[WIDTH+1], mcand};
    assign x2 = {mcand, 1'b0};

    always_comb begin
        sel = SEL_ZERO;
        case (triplet)
            3'b001, 3'b010: sel = SEL_P1;
            3'b011:         sel = SEL_P2;
            3'b100:         sel = SEL_N2;
            3'b101, 3'b110: sel = SEL_N1;
            default:        sel = SEL_ZERO;
        endcase
    end

    // Negative selections are emitted inverted; the +1 rides in as the adder carry-in.
    always_comb begin
        sel_val = '0;
        neg     = 1'b0;
        case (sel)
            SEL_P1: sel_val = x1;
            SEL_P2: sel_val = x2;
            SEL_N1: begin
                sel_val = ~x1;
                neg     = 1'b1;
            end
            SEL_N2: begin
                sel_val = ~x2;
                neg     = 1'b1;
            end
            default: begin
                sel_val = '0;
                neg     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - iterative radix-4 Booth multiplier, one partial product per clock
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NGRP = ngrp_of(WIDTH);
    localparam int CW   = $clog2(NGRP);
    localparam int AW   = 2 * WIDTH + 2;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] x_reg;
    logic [WIDTH+2:0] y_pad;
    logic [AW-1:0]    acc;

    logic [WIDTH+1:0] x_ext;
    logic [WIDTH+1:0] y_ext;
    logic [WIDTH+2:0] sel_val;
    logic             neg;
    logic [CW:0]      shamt;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    cin_vec;
    logic             unused_acc_top;

    assign x_ext = is_signed ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
    assign y_ext = is_signed ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};

    // y_pad is shifted right two bits per group, so the current triplet is always at [2:0].
    booth_sel_gen #(.WIDTH(WIDTH)) u_sel (
        .triplet (y_pad[2:0]),
        .mcand   (x_reg),
        .sel_val (sel_val),
        .neg     (neg)
    );

    assign shamt   = {cnt, 1'b0};
    assign addend  = {{(WIDTH-1){sel_val[WIDTH+2]}}, sel_val} << shamt;
    assign cin_vec = {{(AW-1){1'b0}}, neg} << shamt;

    assign product        = acc[2*WIDTH-1:0];
    assign unused_acc_top = ^acc[AW-1:2*WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            x_reg     <= '0;
            y_pad     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg    <= x_ext;
                        y_pad    <= {y_ext, 1'b0};
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= acc + addend + cin_vec;
                    y_pad <= {2'b00, y_pad[WIDTH+2:2]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NGRP - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
